// File: rtl/usart_tx_scheduler.sv
// rtl/usart_tx_scheduler.sv - round-robin, burst-locked sharing of one USART Tx core; macro USART_TX_SCHED_PRIO_EN makes requester 0 urgent
module usart_tx_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BIT  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_BIT-1:0]   req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_BIT-1:0]           tx_data,
  input  logic                          tx_busy,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t              state, state_n;
  logic [IDW-1:0]      rr_ptr, rr_ptr_n;
  logic [IDW-1:0]      grant_id_n;
  logic [IDW-1:0]      winner;
  logic [IDW-1:0]      next_owner;
  logic                found;
  logic [BCW-1:0]      burst_cnt, burst_cnt_n;
  logic                last_q, last_n;
  logic                grant_active_n;
  logic                tx_start_n;
  logic [DATA_BIT-1:0] tx_data_n;
  logic [DATA_BIT-1:0] owner_byte;
  logic                burst_done;

  assign owner_byte = req_data[grant_id*DATA_BIT +: DATA_BIT];
  assign next_owner = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
  assign burst_done = last_q || (burst_cnt == BCW'(MAX_BURST));

  // Arbitration: first valid requester scanning upward from rr_ptr, with wrap
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        winner = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
`ifdef USART_TX_SCHED_PRIO_EN
    if (req_valid[0]) begin
      winner = '0;
    end
`endif
  end

  // Consume strobe: only the owner, only in ISSUE, only when it offers a byte
  always_comb begin
    req_ready = '0;
    if (state == ISSUE && req_valid[grant_id]) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Next-state and next-register values for the per-byte sequencer
  always_comb begin
    state_n        = state;
    rr_ptr_n       = rr_ptr;
    grant_id_n     = grant_id;
    grant_active_n = grant_active;
    burst_cnt_n    = burst_cnt;
    last_n         = last_q;
    tx_start_n     = 1'b0;
    tx_data_n      = tx_data;
    unique case (state)
      IDLE: begin
        if (!tx_busy && found) begin
          grant_id_n     = winner;
          grant_active_n = 1'b1;
          burst_cnt_n    = '0;
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        if (req_valid[grant_id]) begin
          tx_start_n = 1'b1;
          tx_data_n  = owner_byte;
          last_n     = req_last[grant_id];
          if (burst_cnt != BCW'(MAX_BURST)) begin
            burst_cnt_n = burst_cnt + BCW'(1);
          end
          state_n = WAIT_ACK;
        end else begin
          grant_active_n = 1'b0;
          rr_ptr_n       = next_owner;
          state_n        = IDLE;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (burst_done) begin
            grant_active_n = 1'b0;
            rr_ptr_n       = next_owner;
            state_n        = IDLE;
          end else begin
            state_n = ISSUE;
`ifdef USART_TX_SCHED_PRIO_EN
            // Urgent requester takes over; rr_ptr untouched so the old owner comes back
            if (req_valid[0] && grant_id != '0) begin
              grant_id_n  = '0;
              burst_cnt_n = '0;
            end
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      burst_cnt    <= '0;
      last_q       <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_ptr_n;
      grant_id     <= grant_id_n;
      grant_active <= grant_active_n;
      burst_cnt    <= burst_cnt_n;
      last_q       <= last_n;
      tx_start     <= tx_start_n;
      tx_data      <= tx_data_n;
    end
  end

endmodule

// File: tb/tb_usart_tx_scheduler.sv
// tb/tb_usart_tx_scheduler.sv - scoreboard bench for usart_tx_scheduler
module tb_usart_tx_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int DATA_BIT  = 8;
  localparam int MAX_BURST = 16;

  logic                        clk       = 1'b0;
  logic                        reset     = 1'b0;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ*DATA_BIT-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]          req_last  = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        tx_start;
  logic [DATA_BIT-1:0]         tx_data;
  logic                        tx_busy   = 1'b0;
  logic                        grant_active;
  logic [1:0]                  grant_id;

  logic [8:0]         rq [NUM_REQ][$];
  logic [11:0]        sb [$];
  logic [NUM_REQ-1:0] en   = '1;
  logic [NUM_REQ-1:0] pend = '0;
  logic [8:0]         pop_tmp;
  logic [11:0]        exp_e;
  int                 busy_cnt = 0;
  int                 n_tests  = 0;
  int                 n_fail   = 0;

  usart_tx_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .DATA_BIT (DATA_BIT),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_active(grant_active),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input int id, input logic [7:0] d, input logic l);
    rq[id].push_back({l, d});
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    sb.push_back({4'(id), d});
  endtask

  task automatic wait_sb(input int n, input bit idle, input string tag);
    int k;
    k = 0;
    while (!(sb.size() <= n && (!idle || (!grant_active && !tx_busy))) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 3000) check(tag, 32'(sb.size()), 32'(n));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Requester FIFOs, Tx core model (busy for 10 cycles per byte) and scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[i] && rq[i].size() > 0) pop_tmp = rq[i].pop_front();
    end
    if (tx_start) begin
      check("start_while_busy", 32'(tx_busy), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_start", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        exp_e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(exp_e[7:0]));
        check("grant_id", 32'(grant_id), 32'(exp_e[11:8]));
        check("grant_active", 32'(grant_active), 32'd1);
      end
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = en[i] && (rq[i].size() > 0);
      if (rq[i].size() > 0) begin
        req_data[i*DATA_BIT +: DATA_BIT] = rq[i][0][7:0];
        req_last[i] = rq[i][0][8];
      end else begin
        req_data[i*DATA_BIT +: DATA_BIT] = '0;
        req_last[i] = 1'b0;
      end
    end
    #3;
    pend = req_ready;
    if (pend != '0) check("ready_onehot", 32'($onehot(pend)), 32'd1);
  end

  initial begin
    int viol;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;

    // Single requester 1, three bytes, last on the third
    @(posedge clk);
    #1;
    push_req(1, 8'hA5, 1'b0); push_req(1, 8'h3C, 1'b0); push_req(1, 8'h7E, 1'b1);
    push_exp(1, 8'hA5); push_exp(1, 8'h3C); push_exp(1, 8'h7E);
    wait_sb(0, 1'b1, "t1_timeout");
    // Pointer is now 2: requester 2 must beat requester 1
    push_req(1, 8'h11, 1'b1); push_req(2, 8'h22, 1'b1);
    push_exp(2, 8'h22); push_exp(1, 8'h11);
    wait_sb(0, 1'b1, "t1_ptr_timeout");

    // All four requesters with one-byte packets from rr_ptr=0
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      push_req(i, 8'(8'h40 + i), 1'b1);
      push_exp(i, 8'(8'h40 + i));
    end
    wait_sb(0, 1'b1, "t2_timeout");
    // Pointer wrapped to 0: requester 0 before requester 3
    push_req(3, 8'h53, 1'b1); push_req(0, 8'h50, 1'b1);
    push_exp(0, 8'h50); push_exp(3, 8'h53);
    wait_sb(0, 1'b1, "t2_wrap_timeout");

    // Burst limit: 20 bytes from requester 2 with requester 3 waiting
    for (int i = 0; i < 20; i++) push_req(2, 8'(8'h80 + i), 1'b0);
    push_req(3, 8'hC3, 1'b1);
    for (int i = 0; i < 16; i++) push_exp(2, 8'(8'h80 + i));
    push_exp(3, 8'hC3);
    for (int i = 16; i < 20; i++) push_exp(2, 8'(8'h80 + i));
    wait_sb(0, 1'b1, "t3_timeout");

    // Owner drops valid mid-burst
    for (int i = 0; i < 5; i++) push_req(1, 8'(8'h90 + i), 1'b0);
    push_req(2, 8'hB2, 1'b1);
    push_exp(1, 8'h90); push_exp(1, 8'h91); push_exp(2, 8'hB2);
    push_exp(1, 8'h92); push_exp(1, 8'h93); push_exp(1, 8'h94);
    wait_sb(4, 1'b0, "t5_first_timeout");
    en[1] = 1'b0;
    wait_sb(3, 1'b1, "t5_release_timeout");
    en[1] = 1'b1;
    wait_sb(0, 1'b1, "t5_timeout");

    // Reset while the owner waits in WAIT_DONE
    push_req(0, 8'hE0, 1'b0); push_req(0, 8'hE1, 1'b0); push_req(0, 8'hE2, 1'b1);
    push_exp(0, 8'hE0);
    wait_sb(0, 1'b0, "t4_start_timeout");
    repeat (4) @(posedge clk);
    #1;
    check("t4_pre_grant_active", 32'(grant_active), 32'd1);
    push_req(3, 8'hE3, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t4_grant_active", 32'(grant_active), 32'd0);
    check("t4_tx_start", 32'(tx_start), 32'd0);
    check("t4_grant_id", 32'(grant_id), 32'd0);
    check("t4_busy_still_high", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    viol = 0;
    k = 0;
    while (tx_busy && k < 100) begin
      if (req_ready != '0) viol++;
      @(posedge clk);
      #1;
      k++;
    end
    check("t4_ready_while_busy", 32'(viol), 32'd0);
    push_exp(0, 8'hE1); push_exp(0, 8'hE2); push_exp(3, 8'hE3);
    wait_sb(0, 1'b1, "t4_timeout");

`ifdef USART_TX_SCHED_PRIO_EN
    // Urgent requester 0 pre-empts a burst from requester 1
    pulse_reset();
    for (int i = 0; i < 4; i++) push_req(1, 8'(8'hD0 + i), 1'b0);
    push_exp(1, 8'hD0);
    wait_sb(0, 1'b0, "t6_start_timeout");
    push_req(0, 8'hDF, 1'b1);
    push_exp(0, 8'hDF); push_exp(1, 8'hD1); push_exp(1, 8'hD2); push_exp(1, 8'hD3);
    wait_sb(0, 1'b1, "t6_timeout");
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
